// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder driving one full-adder cell.
// Operands shift LSB-first; result and carry registered at completion.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              request, sampled only while idle
//   a_in, b_in         parallel operands, sampled when start is accepted
//   carry_in           initial carry, sampled when start is accepted
//   sub                (SERIAL_ADDER_SUB_EN only) subtract A-B
//   busy               high while an addition is in progress
//   done               one-cycle pulse, result valid
//   sum_out, carry_out registered result, held until next completion
//
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port.

module full_adder_dataflow (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             carry_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_c;
    // Only WIDTH-1 bits are kept; the oldest bit lives in w_sum_next[0].
    logic [WIDTH-2:0] r_sum_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic [WIDTH-1:0] r_sum_out;
    logic             r_carry_out;

    logic             w_cell_sum;
    logic             w_cell_cout;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtract as A + ~B + 1; carry_out=1 then means no borrow.
    assign w_b_load = sub ? ~b_in : b_in;
    assign w_c_load = sub ? 1'b1 : carry_in;
`else
    assign w_b_load = b_in;
    assign w_c_load = carry_in;
`endif

    full_adder_dataflow u_cell (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_c),
        .sum  (w_cell_sum),
        .cout (w_cell_cout)
    );

    assign w_sum_next = {w_cell_sum, r_sum_sh};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                    w_load       = 1'b1;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_c         <= 1'b0;
            r_sum_sh    <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_sum_out   <= '0;
            r_carry_out <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_a_sh <= a_in;
                r_b_sh <= w_b_load;
                r_c    <= w_c_load;
                r_cnt  <= '0;
            end else if (w_step) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_c      <= w_cell_cout;
                r_sum_sh <= w_sum_next[WIDTH-1:1];
                r_cnt    <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_sum_out   <= w_sum_next;
                    r_carry_out <= w_cell_cout;
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign sum_out   = r_sum_out;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed bench for serial_adder_ctrl (WIDTH=8).
// Expected values are hand-computed constants.

module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         carry_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         carry_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .carry_in  (carry_in),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives start in the current cycle (caller is just past a negedge)
    // and watches 9 cycles; returns with done expected high.
    task automatic run(input string tag, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin,
                       input logic s, input logic [W-1:0] exp_sum,
                       input logic exp_c);
        int busy_cnt;
        int done_at;
        busy_cnt = 0;
        done_at  = 0;
        a_in     = a;
        b_in     = b;
        carry_in = cin;
        sub      = s;
        start    = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                chk({tag, "_done_low_k1"}, 32'(done), 32'd0);
            end
            // operands must not be resampled while busy
            a_in     = W'($urandom);
            b_in     = W'($urandom);
            carry_in = 1'($urandom);
            sub      = 1'($urandom);
            if (busy) busy_cnt++;
            if (done && done_at == 0) done_at = k;
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd8);
        chk({tag, "_done_at"}, 32'(done_at), 32'd9);
        chk({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(carry_out), 32'(exp_c));
    endtask

    initial begin
        int n_done;
        logic [W-1:0] seen_sum;
        reset    = 1'b1;
        start    = 1'b0;
        a_in     = '0;
        b_in     = '0;
        carry_in = 1'b0;
        sub      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_cout", 32'(carry_out), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("t1_3p5", 8'd3, 8'd5, 1'b0, 1'b0, 8'd8, 1'b0);
        @(negedge clk);
        chk("t1_done_fall", 32'(done), 32'd0);
        chk("t1_sum_hold", 32'(sum_out), 32'd8);

        run("t2_255p1", 8'd255, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        run("t2_cin", 8'd0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0);
        @(negedge clk);

        // start while busy must be ignored
        a_in  = 8'd10;
        b_in  = 8'd20;
        carry_in = 1'b0;
        start = 1'b1;
        n_done = 0;
        seen_sum = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) begin
                a_in  = 8'd1;
                b_in  = 8'd1;
                start = 1'b1;
            end
            if (done) begin
                n_done++;
                seen_sum = sum_out;
            end
        end
        chk("t3_done_count", 32'(n_done), 32'd1);
        chk("t3_sum", 32'(seen_sum), 32'd30);
        chk("t3_busy_idle", 32'(busy), 32'd0);

        // reset mid-run aborts with no done pulse
        a_in  = 8'd100;
        b_in  = 8'd27;
        start = 1'b1;
        n_done = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (k == 5);
            if (done) n_done++;
        end
        chk("t4_no_done", 32'(n_done), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_sum", 32'(sum_out), 32'd0);
        chk("t4_cout", 32'(carry_out), 32'd0);
        run("t4_7p9", 8'd7, 8'd9, 1'b0, 1'b0, 8'd16, 1'b0);
        @(negedge clk);

        // back-to-back: second start in the done cycle
        run("t5_1p2", 8'd1, 8'd2, 1'b0, 1'b0, 8'd3, 1'b0);
        run("t5_4p4", 8'd4, 8'd4, 1'b0, 1'b0, 8'd8, 1'b0);
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run("t6_5m3", 8'd5, 8'd3, 1'b0, 1'b1, 8'd2, 1'b1);
        @(negedge clk);
        run("t6_3m5", 8'd3, 8'd5, 1'b0, 1'b1, 8'd254, 1'b0);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
